// File: rtl/dec_bin16_pkg.sv
// rtl/dec_bin16_pkg.sv - shared constants, FSM encoding and BCD digit check for the decimal chain
// Purpose : common definitions for dec_bin16 (BCD->binary) and the bin_dec chain.
// Ports   : none (package).
package dec_bin16_pkg;

    localparam int NDIGITS = 5;
    localparam int BIN_W   = 16;
    localparam int ACC_W   = 17;   // holds 10**NDIGITS-1 = 99999
    localparam int BCD_MAX = 9;
    localparam int IDX_W   = 3;    // enough to count NDIGITS-1 down to 0

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // High when any nibble of the packed BCD word is not a decimal digit.
    function automatic logic has_bad_digit(input logic [4*NDIGITS-1:0] bcd);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'(BCD_MAX)) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

endpackage

// File: rtl/dec_bin16_if.sv
// rtl/dec_bin16_if.sv - request/result bundle between the decimal entry path and dec_bin16
// Purpose : groups the conversion request and result signals.
// Signals : start, dec_in (requester -> converter); busy, done, bin_out, ovf, bad_digit (converter -> requester).
interface dec_bin16_if;
    import dec_bin16_pkg::*;

    logic                   start;
    logic [4*NDIGITS-1:0]   dec_in;
    logic                   busy;
    logic                   done;
    logic [BIN_W-1:0]       bin_out;
    logic                   ovf;
    logic                   bad_digit;

    modport master (
        output start, dec_in,
        input  busy, done, bin_out, ovf, bad_digit
    );

    modport slave (
        input  start, dec_in,
        output busy, done, bin_out, ovf, bad_digit
    );

endinterface

// File: rtl/dec_mul10_add.sv
// rtl/dec_mul10_add.sv - combinational acc*10 + digit step of the BCD->binary loop
// Purpose : one iteration of the Horner evaluation of a decimal number.
// Ports   : acc_in [ACC_W] running value, digit [4] next BCD digit, acc_out [ACC_W] acc_in*10+digit.
module dec_mul10_add
    import dec_bin16_pkg::*;
(
    input  logic [ACC_W-1:0] acc_in,
    input  logic [3:0]       digit,
    output logic [ACC_W-1:0] acc_out
);

    // acc_in never exceeds 9999 when a step is taken, so the shifted terms fit ACC_W.
    assign acc_out = (acc_in << 3) + (acc_in << 1) + {{(ACC_W-4){1'b0}}, digit};

endmodule

// File: rtl/dec_bin16.sv
// rtl/dec_bin16.sv - sequential 5-digit BCD to 16-bit binary converter, one digit per clock
// Purpose : converts a packed BCD word captured on start into a saturated unsigned binary value.
// Ports   : clk, reset_n (synchronous, active-low); bus (slave modport): start, dec_in in;
//           busy, done (one-cycle pulse), bin_out, ovf, bad_digit out.
module dec_bin16
    import dec_bin16_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    dec_bin16_if.slave  bus
);

    localparam logic [ACC_W-1:0] BIN_MAX_ACC = {{(ACC_W-BIN_W){1'b0}}, {BIN_W{1'b1}}};

    state_e                 state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [4*NDIGITS-1:0]   shadow_q, shadow_d;
    logic [BIN_W-1:0]       bin_q, bin_d;
    logic                   ovf_q, ovf_d;
    logic                   bad_q, bad_d;

    logic [3:0]             digit;
    logic [ACC_W-1:0]       acc_step;

    // Digits are consumed most significant first, from the captured copy of dec_in.
    assign digit = shadow_q[{idx_q, 2'b00} +: 4];

    dec_mul10_add u_mul10_add (
        .acc_in  (acc_q),
        .digit   (digit),
        .acc_out (acc_step)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        shadow_d = shadow_q;
        bin_d    = bin_q;
        ovf_d    = ovf_q;
        bad_d    = bad_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    shadow_d = bus.dec_in;
                    if (has_bad_digit(bus.dec_in)) begin
                        state_d = ST_DONE;
                        bin_d   = '0;
                        ovf_d   = 1'b0;
                        bad_d   = 1'b1;
                    end else begin
                        state_d = ST_CONV;
                        acc_d   = '0;
                        idx_d   = IDX_W'(NDIGITS-1);
                    end
                end
            end
            ST_CONV: begin
                acc_d = acc_step;
                idx_d = idx_q - 1'b1;
                if (idx_q == '0) begin
                    // Last digit: results are taken from the final step directly.
                    state_d = ST_DONE;
                    idx_d   = '0;
                    bad_d   = 1'b0;
                    if (acc_step > BIN_MAX_ACC) begin
                        ovf_d = 1'b1;
                        bin_d = '1;
                    end else begin
                        ovf_d = 1'b0;
                        bin_d = acc_step[BIN_W-1:0];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            idx_q    <= '0;
            shadow_q <= '0;
            bin_q    <= '0;
            ovf_q    <= 1'b0;
            bad_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            shadow_q <= shadow_d;
            bin_q    <= bin_d;
            ovf_q    <= ovf_d;
            bad_q    <= bad_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.bin_out   = bin_q;
    assign bus.ovf       = ovf_q;
    assign bus.bad_digit = bad_q;

endmodule

// File: tb/tb_dec_bin16.sv
// tb/tb_dec_bin16.sv - directed self-checking bench for dec_bin16
module tb_dec_bin16;
    import dec_bin16_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    dec_bin16_if bus ();

    dec_bin16 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    int          cap_lat;
    int          cap_ndone;
    logic [15:0] cap_bin;
    logic        cap_ovf;
    logic        cap_bad;

    // Issue one request and watch 12 cycles: first DONE latency, DONE count, captured results.
    task automatic run_conv(input logic [19:0] d);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.dec_in = d;
        @(posedge clk);
        cap_lat   = 0;
        cap_ndone = 0;
        cap_bin   = 16'h0;
        cap_ovf   = 1'b0;
        cap_bad   = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                cap_ndone++;
                if (cap_lat == 0) begin
                    cap_lat = k;
                    cap_bin = bus.bin_out;
                    cap_ovf = bus.ovf;
                    cap_bad = bus.bad_digit;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        bus.start  = 1'b1;
        bus.dec_in = 20'h12345;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
        vectors++; if (bus.bin_out !== 16'h0) begin miscompares++; $display("FAIL reset_bin got %h want 0000", bus.bin_out); end
        vectors++; if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL reset_ovf got %b want 0", bus.ovf); end
        vectors++; if (bus.bad_digit !== 1'b0) begin miscompares++; $display("FAIL reset_bad got %b want 0", bus.bad_digit); end
        bus.start = 1'b0;
        reset_n   = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_basic();
        logic exp_busy, exp_done;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.dec_in = 20'h12345;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            exp_busy = (k <= 6);
            exp_done = (k == 6);
            vectors++; if (bus.busy !== exp_busy) begin miscompares++; $display("FAIL basic_busy k=%0d got %b want %b", k, bus.busy, exp_busy); end
            vectors++; if (bus.done !== exp_done) begin miscompares++; $display("FAIL basic_done k=%0d got %b want %b", k, bus.done, exp_done); end
            if (k == 6) begin
                vectors++; if (bus.bin_out !== 16'h3039) begin miscompares++; $display("FAIL basic_bin got %h want 3039", bus.bin_out); end
                vectors++; if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL basic_ovf got %b want 0", bus.ovf); end
                vectors++; if (bus.bad_digit !== 1'b0) begin miscompares++; $display("FAIL basic_bad got %b want 0", bus.bad_digit); end
            end
        end
        vectors++; if (bus.bin_out !== 16'h3039) begin miscompares++; $display("FAIL basic_hold got %h want 3039", bus.bin_out); end
    endtask

    task automatic test_boundaries();
        logic [19:0] din  [4] = '{20'h00000, 20'h65535, 20'h65536, 20'h99999};
        logic [15:0] ebin [4] = '{16'h0000, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        logic        eovf [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            run_conv(din[i]);
            vectors++; if (cap_lat !== 6) begin miscompares++; $display("FAIL bound_lat in=%h got %0d want 6", din[i], cap_lat); end
            vectors++; if (cap_ndone !== 1) begin miscompares++; $display("FAIL bound_ndone in=%h got %0d want 1", din[i], cap_ndone); end
            vectors++; if (cap_bin !== ebin[i]) begin miscompares++; $display("FAIL bound_bin in=%h got %h want %h", din[i], cap_bin, ebin[i]); end
            vectors++; if (cap_ovf !== eovf[i]) begin miscompares++; $display("FAIL bound_ovf in=%h got %b want %b", din[i], cap_ovf, eovf[i]); end
            vectors++; if (cap_bad !== 1'b0) begin miscompares++; $display("FAIL bound_bad in=%h got %b want 0", din[i], cap_bad); end
        end
    endtask

    task automatic test_bad_digit();
        logic [19:0] din [3] = '{20'h1A345, 20'h0000F, 20'hA0000};
        for (int i = 0; i < 3; i++) begin
            run_conv(din[i]);
            vectors++; if (cap_lat !== 1) begin miscompares++; $display("FAIL bad_lat in=%h got %0d want 1", din[i], cap_lat); end
            vectors++; if (cap_ndone !== 1) begin miscompares++; $display("FAIL bad_ndone in=%h got %0d want 1", din[i], cap_ndone); end
            vectors++; if (cap_bin !== 16'h0) begin miscompares++; $display("FAIL bad_bin in=%h got %h want 0000", din[i], cap_bin); end
            vectors++; if (cap_ovf !== 1'b0) begin miscompares++; $display("FAIL bad_ovf in=%h got %b want 0", din[i], cap_ovf); end
            vectors++; if (cap_bad !== 1'b1) begin miscompares++; $display("FAIL bad_flag in=%h got %b want 1", din[i], cap_bad); end
        end
        run_conv(20'h00123);
        vectors++; if (cap_lat !== 6) begin miscompares++; $display("FAIL bad_clear_lat got %0d want 6", cap_lat); end
        vectors++; if (cap_bin !== 16'h007B) begin miscompares++; $display("FAIL bad_clear_bin got %h want 007b", cap_bin); end
        vectors++; if (cap_bad !== 1'b0) begin miscompares++; $display("FAIL bad_clear_flag got %b want 0", cap_bad); end
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        @(negedge clk);
        bus.start  = 1'b1;
        bus.dec_in = 20'h00042;
        @(posedge clk);
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            if (k == 2) bus.dec_in = 20'h00099;
            if (k == 4) bus.dec_in = 20'h00042;
            exp_done = (k == 6) || (k == 13) || (k == 20);
            vectors++; if (bus.done !== exp_done) begin miscompares++; $display("FAIL b2b_done k=%0d got %b want %b", k, bus.done, exp_done); end
            if (exp_done) begin
                vectors++; if (bus.bin_out !== 16'h002A) begin miscompares++; $display("FAIL b2b_bin k=%0d got %h want 002a", k, bus.bin_out); end
            end
        end
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    task automatic test_reset_abort();
        run_conv(20'h12345);
        vectors++; if (cap_bin !== 16'h3039) begin miscompares++; $display("FAIL abort_pre_bin got %h want 3039", cap_bin); end
        @(negedge clk);
        bus.start  = 1'b1;
        bus.dec_in = 20'h54321;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 1) bus.start = 1'b0;
            vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL abort_done k=%0d got %b want 0", k, bus.done); end
            if (k == 3) reset_n = 1'b0;
            if (k == 4) begin
                vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", bus.busy); end
                vectors++; if (bus.bin_out !== 16'h0) begin miscompares++; $display("FAIL abort_bin got %h want 0000", bus.bin_out); end
                vectors++; if (bus.ovf !== 1'b0) begin miscompares++; $display("FAIL abort_ovf got %b want 0", bus.ovf); end
                vectors++; if (bus.bad_digit !== 1'b0) begin miscompares++; $display("FAIL abort_bad got %b want 0", bus.bad_digit); end
                reset_n = 1'b1;
            end
        end
        run_conv(20'h00007);
        vectors++; if (cap_lat !== 6) begin miscompares++; $display("FAIL abort_post_lat got %0d want 6", cap_lat); end
        vectors++; if (cap_bin !== 16'h0007) begin miscompares++; $display("FAIL abort_post_bin got %h want 0007", cap_bin); end
    endtask

    task automatic test_sweep();
        int          v, p;
        logic [19:0] bcd;
        logic [15:0] ebin;
        logic        eovf;
        for (int n = 0; n < 40; n++) begin
            v = int'($urandom_range(0, 99999));
            p = 1;
            for (int i = 0; i < 5; i++) begin
                bcd[4*i +: 4] = 4'((v / p) % 10);
                p = p * 10;
            end
            eovf = (v > 65535);
            ebin = eovf ? 16'hFFFF : 16'(v);
            run_conv(bcd);
            vectors++; if (cap_ndone !== 1) begin miscompares++; $display("FAIL sweep_ndone v=%0d got %0d want 1", v, cap_ndone); end
            vectors++; if (cap_lat !== 6) begin miscompares++; $display("FAIL sweep_lat v=%0d got %0d want 6", v, cap_lat); end
            vectors++; if (cap_bin !== ebin) begin miscompares++; $display("FAIL sweep_bin v=%0d got %h want %h", v, cap_bin, ebin); end
            vectors++; if (cap_ovf !== eovf) begin miscompares++; $display("FAIL sweep_ovf v=%0d got %b want %b", v, cap_ovf, eovf); end
        end
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.dec_in = 20'h0;
        test_reset();
        test_basic();
        test_boundaries();
        test_bad_digit();
        test_back_to_back();
        test_reset_abort();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
